// File: rtl/lpf_decim_pkg.sv
// Shared constants and state encoding for the moving-sum filter chain.
package lpf_decim_pkg;

   localparam int unsigned DATA_W     = 18;
   localparam int unsigned WARMUP_DEF = 10;
   localparam int unsigned DECIM_DEF  = 4;
   localparam int unsigned SHIFT_DEF  = 3;

   typedef enum logic {
      WARM = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/lpf_fifo2.sv
// Two-entry first-word-fall-through buffer; slot0 is always the head.
module lpf_fifo2
   import lpf_decim_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              valid_o,
   output logic              full_o
);

   logic [DATA_W-1:0] slot0_q, slot0_d;
   logic [DATA_W-1:0] slot1_q, slot1_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              pop_eff;

   assign pop_eff = pop_i && (cnt_q != 2'd0);

   // A pop with a single entry leaves slot0 untouched so the head value lingers.
   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      cnt_d   = cnt_q;
      if (flush_i) begin
         cnt_d = 2'd0;
      end else if (push_i && pop_eff) begin
         if (cnt_q == 2'd1) begin
            slot0_d = din_i;
         end else begin
            slot0_d = slot1_q;
            slot1_d = din_i;
         end
      end else if (push_i) begin
         if (cnt_q == 2'd0) begin
            slot0_d = din_i;
            cnt_d   = 2'd1;
         end else if (cnt_q == 2'd1) begin
            slot1_d = din_i;
            cnt_d   = 2'd2;
         end
      end else if (pop_eff) begin
         if (cnt_q == 2'd2) begin
            slot0_d = slot1_q;
         end
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot0_q <= '0;
         slot1_q <= '0;
         cnt_q   <= 2'd0;
         valid_o <= 1'b0;
         full_o  <= 1'b0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         cnt_q   <= cnt_d;
         valid_o <= (cnt_d != 2'd0);
         full_o  <= (cnt_d == 2'd2);
      end
   end

   assign dout_o = slot0_q;

endmodule

// File: rtl/lpf_decim.sv
// Warm-up discard, /2^SHIFT normalisation and decimation of the moving-sum stream.
module lpf_decim
   import lpf_decim_pkg::*;
#(
   parameter int unsigned WARMUP = WARMUP_DEF,
   parameter int unsigned DECIM  = DECIM_DEF,
   parameter int unsigned SHIFT  = SHIFT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic [DATA_W-1:0] sum_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              ovf,
   input  logic              ovf_clr,
   output logic              warm
);

   localparam int unsigned WU_W = 16;
   localparam int unsigned PH_W = 8;

   state_e            state_q, state_d;
   logic [WU_W-1:0]   wcnt_q, wcnt_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              ovf_d;
   logic              warm_d;
   logic              push;
   logic              pop;
   logic              full;
   logic [DATA_W-1:0] norm;

   assign norm = DATA_W'(sum_in >> SHIFT);
   assign pop  = out_valid && out_ready;

   // Next state, counters and push strobe; restart overrides everything.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      phase_d = phase_q;
      push    = 1'b0;
      if (restart) begin
         state_d = WARM;
         wcnt_d  = '0;
         phase_d = '0;
      end else begin
         unique case (state_q)
            WARM: begin
               if (wcnt_q == WU_W'(WARMUP - 1)) begin
                  state_d = RUN;
                  wcnt_d  = '0;
               end else begin
                  wcnt_d = wcnt_q + WU_W'(1);
               end
            end
            RUN: begin
               if (phase_q == PH_W'(DECIM - 1)) begin
                  push    = 1'b1;
                  phase_d = '0;
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
         endcase
      end
      ovf_d = ovf_q_int();
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (push && full && !pop) begin
         ovf_d = 1'b1;
      end
      warm_d = (state_d == WARM);
   end

   function automatic logic ovf_q_int();
      return ovf;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WARM;
         wcnt_q  <= '0;
         phase_q <= '0;
         ovf     <= 1'b0;
         warm    <= 1'b1;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         phase_q <= phase_d;
         ovf     <= ovf_d;
         warm    <= warm_d;
      end
   end

   lpf_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (restart),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   (norm),
      .dout_o  (out_data),
      .valid_o (out_valid),
      .full_o  (full)
   );

endmodule

// File: tb/tb_lpf_decim.sv
// Randomised bench for lpf_decim against a queue-based reference model.
module tb_lpf_decim;
   import lpf_decim_pkg::*;

   localparam int unsigned DW = DATA_W;
   localparam int unsigned WU = WARMUP_DEF;
   localparam int unsigned DC = DECIM_DEF;
   localparam int unsigned SH = SHIFT_DEF;

   logic          clk;
   logic          rst_n;
   logic          restart;
   logic [DW-1:0] sum_in;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          ovf;
   logic          ovf_clr;
   logic          warm;

   lpf_decim #(.WARMUP(WU), .DECIM(DC), .SHIFT(SH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .restart   (restart),
      .sum_in    (sum_in),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .warm      (warm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference state: queue of buffered samples, last head seen, cycles since (re)start.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] m_last;
   bit            m_ovf;
   int            t;
   int            n_chk;
   int            n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit sel_now();
      return !restart && (t >= int'(WU)) && (((t - int'(WU)) % int'(DC)) == int'(DC) - 1);
   endfunction

   task automatic model_reset();
      mq.delete();
      m_last = '0;
      m_ovf  = 1'b0;
      t      = 0;
   endtask

   task automatic model_update();
      bit pop_m, sel_m, ovfev;
      ovfev = 1'b0;
      if (restart) begin
         mq.delete();
         t = 0;
      end else begin
         pop_m = (mq.size() > 0) && out_ready;
         sel_m = sel_now();
         ovfev = sel_m && (mq.size() == 2) && !pop_m;
         if (pop_m) void'(mq.pop_front());
         if (sel_m && !ovfev) mq.push_back(sum_in / DW'(1 << SH));
         t++;
      end
      if (ovf_clr) m_ovf = 1'b0;
      if (ovfev)   m_ovf = 1'b1;
      if (mq.size() > 0) m_last = mq[0];
   endtask

   task automatic check_all();
      check("valid", 32'(out_valid), 32'(mq.size() > 0));
      check("data",  32'(out_data),  32'(m_last));
      check("ovf",   32'(ovf),       32'(m_ovf));
      check("warm",  32'(warm),      32'(t < int'(WU)));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_all();
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      restart   = 1'b0;
      sum_in    = '0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      model_reset();
      #22;
      rst_n = 1'b1;
      check_all();

      // Constant input: first output at cycle WARMUP+DECIM
      sum_in    = 18'h00800;
      out_ready = 1'b1;
      repeat (int'(WU + DC)) step();
      check("first_valid", 32'(out_valid), 32'd1);
      check("first_data",  32'(out_data),  32'h00100);
      repeat (16) step();

      // Ramp by 8 per cycle
      for (int i = 0; i < 24; i++) begin
         sum_in = DW'(i * 8 + 104);
         step();
      end

      // Stall consumer until overflow, then pop only on push cycles (full pop+push)
      out_ready = 1'b0;
      for (int i = 0; i < 14; i++) begin
         sum_in = DW'($urandom);
         step();
      end
      check("ovf_set", 32'(ovf), 32'd1);
      for (int i = 0; i < 16; i++) begin
         sum_in    = DW'($urandom);
         out_ready = sel_now();
         step();
      end
      out_ready = 1'b1;
      repeat (8) step();
      check("ovf_sticky", 32'(ovf), 32'd1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf), 32'd0);

      // Restart with one entry buffered
      out_ready = 1'b0;
      for (int i = 0; i < 12 && mq.size() != 1; i++) begin
         sum_in = DW'($urandom);
         step();
      end
      check("one_entry", 32'(mq.size()), 32'd1);
      restart = 1'b1;
      step();
      restart = 1'b0;
      check("restart_valid", 32'(out_valid), 32'd0);
      check("restart_warm",  32'(warm),      32'd1);
      out_ready = 1'b1;
      repeat (20) step();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         sum_in    = DW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         restart   = ($urandom_range(0, 49) == 0);
         ovf_clr   = ($urandom_range(0, 19) == 0);
         step();
      end
      restart = 1'b0;
      ovf_clr = 1'b0;

      // Asynchronous reset mid-cycle with a full buffer
      out_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         sum_in = DW'($urandom | 32'h8);
         step();
      end
      check("full_before_rst", 32'(mq.size()), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_data", 32'(out_data), 32'd0);
      #2;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         sum_in = DW'($urandom);
         step();
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
